nios_setup_mem_loader: RTL and testbench

- Boot-image loader sitting directly upstream of the on-chip memory's second slave port (s2).
- Consumes a framed byte stream (from the host UART/JTAG bridge) via valid/ready, assembles little-endian 32-bit words and writes them into on-chip RAM through the s2 write signals.
- Frame is sync byte, 4-byte header (start word address, word count), payload, checksum byte; reports done/error status to the Nios control register block.

---
 rtl/nios_setup_loader_pkg.sv | 23 ++
 rtl/nios_setup_loader_acc.sv | 27 ++
 rtl/nios_setup_mem_loader.sv | 179 +++++++++++++++++
 tb/tb_nios_setup_mem_loader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/nios_setup_loader_pkg.sv
// Shared definitions for the boot-image loader: FSM encoding, frame constants and limits.
package nios_setup_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StHdr   = 3'd1;
    localparam state_t StData  = 3'd2;
    localparam state_t StWrite = 3'd3;
    localparam state_t StCsum  = 3'd4;
    localparam state_t StDone  = 3'd5;
    localparam state_t StErr   = 3'd6;

    localparam logic [7:0]  SyncByteDefault = 8'hA5;
    localparam int unsigned MaxWordsDefault = 4096;

    // Header byte order after the sync byte
    localparam logic [1:0] HdrAddrLo = 2'd0;
    localparam logic [1:0] HdrAddrHi = 2'd1;
    localparam logic [1:0] HdrCntLo  = 2'd2;
    localparam logic [1:0] HdrCntHi  = 2'd3;

endpackage

// File: rtl/nios_setup_loader_acc.sv
// 8-bit modular checksum accumulator; sum_zero tells whether adding data would give zero.
module nios_setup_loader_acc (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       add,
    input  logic [7:0] data,
    output logic [7:0] sum,
    output logic       sum_zero
);

    logic [7:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= 8'h00;
        end else if (clear) begin
            sum_q <= 8'h00;
        end else if (add) begin
            sum_q <= sum_q + data;
        end
    end

    assign sum      = sum_q;
    assign sum_zero = (sum_q + data) == 8'h00;

endmodule

// File: rtl/nios_setup_mem_loader.sv
// Framed byte-stream loader: parses sync/header/payload/checksum and writes words to memory s2.
module nios_setup_mem_loader
    import nios_setup_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned MAX_WORDS = MaxWordsDefault,
    parameter logic [7:0]  SYNC_BYTE = SyncByteDefault
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] address2,
    output logic [3:0]        byteenable2,
    output logic              chipselect2,
    output logic              write2,
    output logic [31:0]       writedata2,
    output logic              clken2,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_written
);

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        addr_lo_q, addr_lo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W:0]   ww_q, ww_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic              acc_clear, acc_add;
    logic [7:0]        acc_sum;
    logic              acc_zero;
    logic [15:0]       addr_full, cnt_full;
    logic [ADDR_W:0]   ww_inc;
    logic              in_write;

    nios_setup_loader_acc u_acc (
        .clk      (clk),
        .reset    (reset),
        .clear    (acc_clear),
        .add      (acc_add),
        .data     (in_data),
        .sum      (acc_sum),
        .sum_zero (acc_zero)
    );

    assign accept    = in_valid && in_ready;
    assign addr_full = {in_data, addr_lo_q};
    assign cnt_full  = {in_data, cnt_q[7:0]};
    assign ww_inc    = ww_q + (ADDR_W+1)'(1);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_lo_d = addr_lo_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        ww_d      = ww_q;
        done_d    = done_q;
        err_d     = err_q;
        acc_clear = 1'b0;
        acc_add   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept && in_data == SYNC_BYTE) begin
                    state_d   = StHdr;
                    idx_d     = 2'd0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    ww_d      = '0;
                    acc_clear = 1'b1;
                end
            end
            StHdr: begin
                if (accept) begin
                    acc_add = 1'b1;
                    idx_d   = idx_q + 2'd1;
                    unique case (idx_q)
                        HdrAddrLo: addr_lo_d = in_data;
                        HdrAddrHi: addr_d = addr_full[ADDR_W-1:0];
                        HdrCntLo:  cnt_d[7:0] = in_data;
                        HdrCntHi: begin
                            cnt_d = cnt_full;
                            if (32'(cnt_full) > MAX_WORDS) begin
                                state_d = StErr;
                                err_d   = 1'b1;
                            end else if (cnt_full == 16'd0) begin
                                state_d = StCsum;
                            end else begin
                                state_d = StData;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StData: begin
                if (accept) begin
                    acc_add                     = 1'b1;
                    word_d[{idx_q, 3'b000} +: 8] = in_data;
                    idx_d                       = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                // Address wraps naturally at the memory depth
                addr_d  = addr_q + ADDR_W'(1);
                ww_d    = ww_inc;
                state_d = (16'(ww_inc) == cnt_q) ? StCsum : StData;
            end
            StCsum: begin
                if (accept) begin
                    if (acc_zero) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
            end
            StDone, StErr: state_d = StIdle;
            default:       state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= 2'd0;
            addr_lo_q <= 8'h00;
            addr_q    <= '0;
            cnt_q     <= 16'h0000;
            word_q    <= 32'h0;
            ww_q      <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_lo_q <= addr_lo_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            ww_q      <= ww_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign in_write = (state_q == StWrite);

    // Held low while reset is asserted, even though the state already reads IDLE
    assign in_ready = !reset && (state_q == StIdle || state_q == StHdr ||
                                 state_q == StData || state_q == StCsum);

    assign address2      = addr_q;
    assign writedata2    = word_q;
    assign byteenable2   = in_write ? 4'hF : 4'h0;
    assign chipselect2   = in_write;
    assign write2        = in_write;
    assign clken2        = 1'b1;
    assign busy          = !(state_q == StIdle || state_q == StDone || state_q == StErr);
    assign done          = done_q;
    assign err           = err_q;
    assign words_written = ww_q;

endmodule

// File: tb/tb_nios_setup_mem_loader.sv
// Scoreboard bench: expected memory writes are queued by the stimulus, checked by a write monitor.
module tb_nios_setup_mem_loader;

    localparam int ADDR_W = 12;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] address2;
    logic [3:0]        byteenable2;
    logic              chipselect2;
    logic              write2;
    logic [31:0]       writedata2;
    logic              clken2;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_written;

    int  compared   = 0;
    int  mismatched = 0;
    wr_t exp_q[$];
    logic [7:0] frame[$];

    nios_setup_mem_loader dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .address2      (address2),
        .byteenable2   (byteenable2),
        .chipselect2   (chipselect2),
        .write2        (write2),
        .writedata2    (writedata2),
        .clken2        (clken2),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Write monitor: every s2 write must match the head of the expected queue
    always @(negedge clk) begin
        if (!reset && write2) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: got addr %0h data %0h, required none",
                         address2, writedata2);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(address2), 32'(e.addr));
                check("wr_data", writedata2, e.data);
                check("wr_be_cs", {27'd0, chipselect2, byteenable2}, {27'd0, 1'b1, 4'hF});
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte was transferred
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            while ($urandom_range(0, 9) < 3) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        foreach (frame[i]) send_byte(frame[i], gaps);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e,
                                input int ww);
        repeat (3) @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_err"}, 32'(err), 32'(e));
        check({tag, "_ww"}, 32'(words_written), 32'(ww));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_pending"}, exp_q.size(), 32'd0);
    endtask

    task automatic push_frame_a();
        exp_q.push_back('{addr: 12'h010, data: 32'h44332211});
        exp_q.push_back('{addr: 12'h011, data: 32'h88776655});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_outs", {address2, byteenable2, chipselect2, write2, busy, done, err},
              '0);
        check("rst_wdata_ww", writedata2 | 32'(words_written), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("clken2", 32'(clken2), 32'd1);

        // Nominal two-word frame
        push_frame_a();
        frame = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'h55, 8'h66, 8'h77, 8'h88, 8'h8A};
        send_frame(1'b0);
        check_status("good", 1'b1, 1'b0, 2);

        // Checksum off by one: writes still happen
        push_frame_a();
        frame[13] = 8'h8B;
        send_frame(1'b0);
        check_status("badcsum", 1'b0, 1'b1, 2);

        // Oversized count 4097
        frame = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h10};
        send_frame(1'b0);
        check_status("oversize", 1'b0, 1'b1, 0);
        send_byte(8'hA5, 1'b0);
        check("resync_err", 32'(err), 32'd0);
        check("resync_busy", 32'(busy), 32'd1);
        // Zero-count frame straight to checksum
        frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(1'b0);
        check_status("zerocnt", 1'b1, 1'b0, 0);

        // Address wrap, payload contains sync value as data
        exp_q.push_back('{addr: 12'hFFF, data: 32'h040302A5});
        exp_q.push_back('{addr: 12'h000, data: 32'h08070605});
        frame = '{8'hA5, 8'hFF, 8'h0F, 8'h02, 8'h00, 8'hA5, 8'h02, 8'h03, 8'h04,
                  8'h05, 8'h06, 8'h07, 8'h08, 8'h28};
        send_frame(1'b0);
        check_status("wrap", 1'b1, 1'b0, 2);

        // Leading garbage and random valid gaps
        push_frame_a();
        frame = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22,
                  8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h8A};
        send_frame(1'b1);
        check_status("gaps", 1'b1, 1'b0, 2);

        // Reset after two payload bytes
        frame = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22};
        send_frame(1'b0);
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_outs", {address2, byteenable2, chipselect2, write2, busy, done, err},
              '0);
        check("midrst_wdata_ww", writedata2 | 32'(words_written), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        push_frame_a();
        frame = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'h55, 8'h66, 8'h77, 8'h88, 8'h8A};
        send_frame(1'b0);
        check_status("after_rst", 1'b1, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
